bcd_to_seven_seg: RTL and testbench

- Registered glyph decoder. It maps a 5-bit character code to a 7-segment pattern.
- One instance per digit in the 8-digit multiplexed display path. The display controller feeds it per-digit codes that spell mood words (FELIZ, NEUTRO, HAMBRE, DESCANSO, MUERTO, AMISTAD, TEST).
- Letter set: the codes cover letters, not decimal digits only. M spans two digits (codes 12 and 17).

---
 rtl/display_glyph_pkg.sv | 84 ++++++++
 rtl/bcd_to_seven_seg.sv | 49 ++++
 tb/tb_bcd_to_seven_seg.sv | 132 +++++++++++++
 3 files changed

// File: rtl/display_glyph_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_glyph_pkg
// Purpose  : Glyph codes and active-low 7-segment patterns shared by the
//            digit decoder and the display controller.
// Revision : 1.0 - initial release
// ============================================================================
package display_glyph_pkg;

    localparam int unsigned GLY_W = 5;
    localparam int unsigned SEG_W = 7;

    localparam logic [GLY_W-1:0] GLY_F     = 5'd0;
    localparam logic [GLY_W-1:0] GLY_E     = 5'd1;
    localparam logic [GLY_W-1:0] GLY_L     = 5'd2;
    localparam logic [GLY_W-1:0] GLY_I     = 5'd3;
    localparam logic [GLY_W-1:0] GLY_Z     = 5'd4;
    localparam logic [GLY_W-1:0] GLY_N     = 5'd5;
    localparam logic [GLY_W-1:0] GLY_U     = 5'd6;
    localparam logic [GLY_W-1:0] GLY_T     = 5'd7;
    localparam logic [GLY_W-1:0] GLY_R     = 5'd8;
    localparam logic [GLY_W-1:0] GLY_O     = 5'd9;
    localparam logic [GLY_W-1:0] GLY_H     = 5'd10;
    localparam logic [GLY_W-1:0] GLY_A     = 5'd11;
    localparam logic [GLY_W-1:0] GLY_ML    = 5'd12;
    localparam logic [GLY_W-1:0] GLY_B     = 5'd13;
    localparam logic [GLY_W-1:0] GLY_D     = 5'd14;
    localparam logic [GLY_W-1:0] GLY_S     = 5'd15;
    localparam logic [GLY_W-1:0] GLY_C     = 5'd16;
    localparam logic [GLY_W-1:0] GLY_MR    = 5'd17;
    localparam logic [GLY_W-1:0] GLY_BLANK = 5'd31;

    // Active-low patterns, bit order gfedcba.
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_L     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_I     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_Z     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_N     = 7'b1001000;
    localparam logic [SEG_W-1:0] SEG_U     = 7'b1000001;
    localparam logic [SEG_W-1:0] SEG_T     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_R     = 7'b0101111;
    localparam logic [SEG_W-1:0] SEG_O     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_H     = 7'b0001001;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_ML    = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_S     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_MR    = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Every code outside the letter set falls through to blank.
    function automatic logic [SEG_W-1:0] glyph_pattern(input logic [GLY_W-1:0] code);
        logic [SEG_W-1:0] pat;
        pat = SEG_BLANK;
        case (code)
            GLY_F:     pat = SEG_F;
            GLY_E:     pat = SEG_E;
            GLY_L:     pat = SEG_L;
            GLY_I:     pat = SEG_I;
            GLY_Z:     pat = SEG_Z;
            GLY_N:     pat = SEG_N;
            GLY_U:     pat = SEG_U;
            GLY_T:     pat = SEG_T;
            GLY_R:     pat = SEG_R;
            GLY_O:     pat = SEG_O;
            GLY_H:     pat = SEG_H;
            GLY_A:     pat = SEG_A;
            GLY_ML:    pat = SEG_ML;
            GLY_B:     pat = SEG_B;
            GLY_D:     pat = SEG_D;
            GLY_S:     pat = SEG_S;
            GLY_C:     pat = SEG_C;
            GLY_MR:    pat = SEG_MR;
            GLY_BLANK: pat = SEG_BLANK;
            default:   pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seven_seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seven_seg
// Purpose  : Registered glyph decoder, 5-bit character code to 7-segment drive.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seven_seg
    import display_glyph_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [GLY_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    localparam logic [SEG_W-1:0] c_blank = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    logic [SEG_W-1:0] w_pattern_al;
    logic [SEG_W-1:0] w_pattern;
    logic [SEG_W-1:0] r_seg;

    assign w_pattern_al = glyph_pattern(bcd);
    assign w_pattern    = ACTIVE_LOW ? w_pattern_al : ~w_pattern_al;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= c_blank;
        end else begin
            r_seg <= w_pattern;
        end
    end

    assign seg = r_seg;

    // Codes past the letter set must never light a segment.
    always_comb begin
        if (bcd >= 5'd18) begin
            assert (w_pattern_al == SEG_BLANK);
        end
    end

    a_blank_high_codes : assert property (
        @(posedge clk) disable iff (rst) (bcd >= 5'd18) |=> (seg == c_blank)
    );

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_seven_seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_seven_seg
// Purpose  : Self-checking bench for both output polarities of the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_seven_seg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] bcd = 5'd0;
    logic [6:0] seg_al;
    logic [6:0] seg_ah;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] glyph_tbl [0:31];

    always #5 clk = ~clk;

    bcd_to_seven_seg #(.ACTIVE_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bcd (bcd),
        .seg (seg_al)
    );

    bcd_to_seven_seg #(.ACTIVE_LOW(1'b0)) dut_inv (
        .clk (clk),
        .rst (rst),
        .bcd (bcd),
        .seg (seg_ah)
    );

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: seg=%b, expected %b", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] model(input logic r, input logic [4:0] code, input bit al);
        logic [6:0] v;
        v = r ? 7'b1111111 : glyph_tbl[code];
        return al ? v : ~v;
    endfunction

    // Apply one cycle of stimulus and check both decoders just after the edge.
    task automatic step(input string tag, input logic r, input logic [4:0] code);
        rst = r;
        bcd = code;
        @(posedge clk);
        #1;
        check({tag, "_al"}, seg_al, model(r, code, 1'b1));
        check({tag, "_ah"}, seg_ah, model(r, code, 1'b0));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) glyph_tbl[i] = 7'b1111111;
        glyph_tbl[0]  = 7'b0001110;
        glyph_tbl[1]  = 7'b0000110;
        glyph_tbl[2]  = 7'b1000111;
        glyph_tbl[3]  = 7'b1111001;
        glyph_tbl[4]  = 7'b0100100;
        glyph_tbl[5]  = 7'b1001000;
        glyph_tbl[6]  = 7'b1000001;
        glyph_tbl[7]  = 7'b0000111;
        glyph_tbl[8]  = 7'b0101111;
        glyph_tbl[9]  = 7'b1000000;
        glyph_tbl[10] = 7'b0001001;
        glyph_tbl[11] = 7'b0001000;
        glyph_tbl[12] = 7'b1001100;
        glyph_tbl[13] = 7'b0000011;
        glyph_tbl[14] = 7'b0100001;
        glyph_tbl[15] = 7'b0010010;
        glyph_tbl[16] = 7'b1000110;
        glyph_tbl[17] = 7'b1111000;

        // Reset held for three edges with a live code on bcd.
        for (int i = 0; i < 3; i++) begin
            step("reset_hold", 1'b1, 5'd1);
            check("reset_literal", seg_al, 7'b1111111);
        end
        check("reset_inv_literal", seg_ah, 7'b0000000);

        // Release: output must stay blank until the next edge.
        rst = 1'b0;
        #1;
        check("release_early", seg_al, 7'b1111111);
        step("release", 1'b0, 5'd1);
        check("release_E", seg_al, 7'b0000110);

        for (int n = 0; n < 32; n++) begin
            step($sformatf("sweep_%0d", n), 1'b0, 5'(n));
        end

        step("b2b_O", 1'b0, 5'd9);
        check("b2b_O_lit", seg_al, 7'b1000000);
        step("b2b_A", 1'b0, 5'd11);
        check("b2b_A_lit", seg_al, 7'b0001000);
        check("polarity_A", seg_ah, 7'b1110111);

        begin
            logic [4:0] muerto [7] = '{5'd12, 5'd17, 5'd6, 5'd1, 5'd8, 5'd7, 5'd9};
            logic [6:0] want   [7] = '{7'b1001100, 7'b1111000, 7'b1000001, 7'b0000110,
                                      7'b0101111, 7'b0000111, 7'b1000000};
            for (int i = 0; i < 7; i++) begin
                step($sformatf("muerto_%0d", i), 1'b0, muerto[i]);
                check($sformatf("muerto_lit_%0d", i), seg_al, want[i]);
            end
        end

        step("stream_S0", 1'b0, 5'd15);
        step("stream_S1", 1'b0, 5'd15);
        step("mid_reset", 1'b1, 5'd15);
        check("mid_reset_lit", seg_al, 7'b1111111);
        check("mid_reset_inv", seg_ah, 7'b0000000);
        step("after_reset", 1'b0, 5'd15);
        check("after_reset_lit", seg_al, 7'b0010010);

        for (int i = 0; i < 300; i++) begin
            step("random", ($urandom_range(15) == 0), 5'($urandom_range(31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
